// File: rtl/tensor_deserializer.sv
// Collects a stream of elements into complete frames and presents each frame as one
// wide word. Two frame banks alternate so one can fill while the other is drained.
module tensor_deserializer #(
    parameter int CH    = 1,
    parameter int IN_H  = 2,
    parameter int IN_W  = 2,
    parameter int WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [WIDTH-1:0]           in_data,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic signed [CH*IN_H*IN_W*WIDTH-1:0] out_vec,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              frame_err,
    output logic [1:0]                        occupancy
);

    localparam int TOTAL = CH * IN_H * IN_W;
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    // Handshake: a beat moves on any rising edge where valid and ready are both high.
    // Neither side may make valid depend on ready; out_vec is stable while out_valid
    // is high and out_ready is low.

    logic [TOTAL*WIDTH-1:0] bank [2];
    logic [1:0]             full;
    logic                   wr_sel;
    logic                   rd_sel;
    logic [CNT_W-1:0]       cnt;
    logic                   err_q;
    logic                   accept;
    logic                   consume;
    logic                   at_last;

    assign at_last = (cnt == LAST);
    assign in_ready  = !full[wr_sel] && !rst;
    assign out_valid = full[rd_sel] && !rst;
    assign out_vec   = rst ? '0 : bank[rd_sel];
    assign occupancy = rst ? 2'd0 : ({1'b0, full[0]} + {1'b0, full[1]});
    assign frame_err = err_q && !rst;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            full    <= 2'b00;
            bank[0] <= '0;
            bank[1] <= '0;
            err_q   <= 1'b0;
        end else begin
            // The element count alone sets frame length; in_last is only cross-checked.
            err_q <= accept && (in_last != at_last);
            if (accept) begin
                bank[wr_sel][int'(cnt)*WIDTH +: WIDTH] <= in_data;
                if (at_last) begin
                    cnt          <= '0;
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= !wr_sel;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // Completion and consumption always hit different banks, so both may apply.
            if (consume) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
        end
    end

endmodule
